mem_arbiter: RTL and testbench

- Shares the core's single synchronous memory port between two requesters: the CPU (instruction fetch and load/store) and a host port (program loader / debug).
- Sits between the control/datapath memory interface and the RAM.
- Each access is a 2-cycle grant/response transaction.
- Requesters stall until they see their ready pulse.

---
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, host) arbiter for a single synchronous memory port.
// Each access takes 2 cycles: a grant cycle, then a response cycle. Round-robin on ties; host_lock blocks the CPU.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_re,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   input  logic              host_re,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_ready,
   input  logic              host_lock,
   output logic              mem_re,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cpu_stall
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_RESP_CPU  = 2'd1;
   localparam logic [1:0] S_RESP_HOST = 2'd2;

   localparam logic G_CPU  = 1'b0;
   localparam logic G_HOST = 1'b1;

   logic [1:0] r_state;
   logic       r_last_grant;
   logic       r_was_write;

   logic w_cpu_req;
   logic w_host_req;
   logic w_cpu_elig;
   logic w_idle;
   logic w_grant_cpu;
   logic w_grant_host;

   assign w_cpu_req  = cpu_re | cpu_we;
   assign w_host_req = host_re | host_we;
   assign w_cpu_elig = w_cpu_req & ~host_lock;

   // Reset kills the grant outright, so a write in the grant cycle never reaches memory.
   assign w_idle       = (r_state == S_IDLE) & ~reset;
   assign w_grant_cpu  = w_idle & w_cpu_elig & (~w_host_req | (r_last_grant == G_HOST));
   assign w_grant_host = w_idle & w_host_req & ~w_grant_cpu;

   always_comb begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_grant_cpu) begin
         mem_re    = cpu_re & ~cpu_we;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (w_grant_host) begin
         mem_re    = host_re & ~host_we;
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

   assign cpu_ready  = ~reset & (r_state == S_RESP_CPU);
   assign host_ready = ~reset & (r_state == S_RESP_HOST);
   assign cpu_rdata  = (cpu_ready & ~r_was_write) ? mem_rdata : '0;
   assign host_rdata = (host_ready & ~r_was_write) ? mem_rdata : '0;
   assign cpu_stall  = w_cpu_req & ~cpu_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= G_HOST;
         r_was_write  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_cpu) begin
                  r_state      <= S_RESP_CPU;
                  r_last_grant <= G_CPU;
                  r_was_write  <= cpu_we;
               end else if (w_grant_host) begin
                  r_state      <= S_RESP_HOST;
                  r_last_grant <= G_HOST;
                  r_was_write  <= host_we;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-by-cycle vector table plus hand sequences for lock, reset and fairness corners.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_re, cpu_we, host_re, host_we, host_lock;
   logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata, mem_rdata;
   logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata;
   logic        cpu_ready, host_ready, mem_re, mem_we, cpu_stall;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .host_re(host_re), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .host_ready(host_ready), .host_lock(host_lock),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
   );

   typedef struct packed {
      logic        rst, cre, cwe;
      logic [31:0] ca, cw;
      logic        hre, hwe;
      logic [31:0] ha, hw;
      logic        lk;
      logic [31:0] mrd;
      logic        e_mre, e_mwe;
      logic [31:0] e_ma, e_mw;
      logic        e_crdy;
      logic [31:0] e_crd;
      logic        e_hrdy;
      logic [31:0] e_hrd;
      logic        e_stall;
   } vec_t;

   vec_t v[64];
   int   nv = 0;

   task automatic add(input logic rst, input logic cre, input logic cwe, input logic [31:0] ca, input logic [31:0] cw,
                      input logic hre, input logic hwe, input logic [31:0] ha, input logic [31:0] hw,
                      input logic lk, input logic [31:0] mrd,
                      input logic e_mre, input logic e_mwe, input logic [31:0] e_ma, input logic [31:0] e_mw,
                      input logic e_crdy, input logic [31:0] e_crd, input logic e_hrdy, input logic [31:0] e_hrd,
                      input logic e_stall);
      v[nv] = '{rst, cre, cwe, ca, cw, hre, hwe, ha, hw, lk, mrd,
                e_mre, e_mwe, e_ma, e_mw, e_crdy, e_crd, e_hrdy, e_hrd, e_stall};
      nv++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      reset = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      host_re = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      host_lock = 1'b0; mem_rdata = '0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic got;

      clear_inputs();
      reset = 1'b1;
      nxt();

      // CPU read alone
      add(1, 0,0,0,0,            0,0,0,0,                 0,0,           0,0,0,0,                  0,0,0,0, 0);
      add(0, 1,0,'h10,0,         0,0,0,0,                 0,0,           1,0,'h10,0,               0,0,0,0, 1);
      add(0, 1,0,'h10,0,         0,0,0,0,                 0,'hDEADBEEF,  0,0,0,0,                  1,'hDEADBEEF,0,0, 0);
      add(0, 0,0,0,0,            0,0,0,0,                 0,0,           0,0,0,0,                  0,0,0,0, 0);
      // host write
      add(0, 0,0,0,0,            0,1,'h20,'h12345678,     0,0,           0,1,'h20,'h12345678,      0,0,0,0, 0);
      add(0, 0,0,0,0,            0,1,'h20,'h12345678,     0,'hAAAA5555,  0,0,0,0,                  0,0,1,0, 0);
      add(0, 0,0,0,0,            0,0,0,0,                 0,0,           0,0,0,0,                  0,0,0,0, 0);
      // contention straight out of reset: CPU, HOST, CPU, HOST
      add(1, 1,0,'h100,0,        1,0,'h200,0,             0,0,           0,0,0,0,                  0,0,0,0, 1);
      for (int k = 0; k < 2; k++) begin
         add(0, 1,0,'h100,0,     1,0,'h200,0,             0,0,           1,0,'h100,0,              0,0,0,0, 1);
         add(0, 1,0,'h100,0,     1,0,'h200,0,             0,'hC0+k,      0,0,0,0,                  1,'hC0+k,0,0, 0);
         add(0, 1,0,'h100,0,     1,0,'h200,0,             0,0,           1,0,'h200,0,              0,0,0,0, 1);
         add(0, 1,0,'h100,0,     1,0,'h200,0,             0,'hE0+k,      0,0,0,0,                  0,0,1,'hE0+k, 1);
      end
      add(0, 0,0,0,0,            0,0,0,0,                 0,0,           0,0,0,0,                  0,0,0,0, 0);
      // host_lock holds the CPU off for 10 cycles
      for (int k = 0; k < 10; k++)
         add(0, 1,0,'h30,0,      0,0,0,0,                 1,0,           0,0,0,0,                  0,0,0,0, 1);
      add(0, 1,0,'h30,0,         0,0,0,0,                 0,0,           1,0,'h30,0,               0,0,0,0, 1);
      add(0, 1,0,'h30,0,         0,0,0,0,                 0,'h77,        0,0,0,0,                  1,'h77,0,0, 0);
      add(0, 0,0,0,0,            0,0,0,0,                 0,0,           0,0,0,0,                  0,0,0,0, 0);
      // reset during a CPU write grant
      add(1, 0,1,'h40,'h55,      0,0,0,0,                 0,0,           0,0,0,0,                  0,0,0,0, 1);
      add(0, 0,1,'h40,'h55,      0,0,0,0,                 0,0,           0,1,'h40,'h55,            0,0,0,0, 1);
      add(0, 0,1,'h40,'h55,      0,0,0,0,                 0,'hFFFF,      0,0,0,0,                  1,0,0,0, 0);
      add(0, 0,0,0,0,            0,0,0,0,                 0,0,           0,0,0,0,                  0,0,0,0, 0);
      // re and we together behave as a write
      add(0, 1,1,'h50,'h99,      0,0,0,0,                 0,0,           0,1,'h50,'h99,            0,0,0,0, 1);
      add(0, 1,1,'h50,'h99,      0,0,0,0,                 0,'h1234,      0,0,0,0,                  1,0,0,0, 0);
      add(0, 0,0,0,0,            0,0,0,0,                 0,0,           0,0,0,0,                  0,0,0,0, 0);

      for (int i = 0; i < nv; i++) begin
         reset = v[i].rst; cpu_re = v[i].cre; cpu_we = v[i].cwe; cpu_addr = v[i].ca; cpu_wdata = v[i].cw;
         host_re = v[i].hre; host_we = v[i].hwe; host_addr = v[i].ha; host_wdata = v[i].hw;
         host_lock = v[i].lk; mem_rdata = v[i].mrd;
         @(negedge clk);
         chk($sformatf("v%0d.mem_re", i),     mem_re,     v[i].e_mre);
         chk($sformatf("v%0d.mem_we", i),     mem_we,     v[i].e_mwe);
         chk($sformatf("v%0d.mem_addr", i),   mem_addr,   v[i].e_ma);
         chk($sformatf("v%0d.mem_wdata", i),  mem_wdata,  v[i].e_mw);
         chk($sformatf("v%0d.cpu_ready", i),  cpu_ready,  v[i].e_crdy);
         chk($sformatf("v%0d.cpu_rdata", i),  cpu_rdata,  v[i].e_crd);
         chk($sformatf("v%0d.host_ready", i), host_ready, v[i].e_hrdy);
         chk($sformatf("v%0d.host_rdata", i), host_rdata, v[i].e_hrd);
         chk($sformatf("v%0d.cpu_stall", i),  cpu_stall,  v[i].e_stall);
         nxt();
      end
      clear_inputs();

      // host_lock raised during RESP_CPU: access completes, later CPU grants blocked
      cpu_re = 1'b1; cpu_addr = 'h60;
      @(negedge clk); chk("lockresp.grant", mem_re, 1); nxt();
      host_lock = 1'b1; mem_rdata = 'h6060;
      @(negedge clk); chk("lockresp.ready", cpu_ready, 1); chk("lockresp.rdata", cpu_rdata, 'h6060); nxt();
      mem_rdata = '0;
      @(negedge clk); chk("lockresp.blocked", mem_re, 0); chk("lockresp.stall", cpu_stall, 1); nxt();
      host_re = 1'b1; host_addr = 'h70;
      @(negedge clk); chk("lockresp.host_addr", mem_addr, 'h70); nxt();
      @(negedge clk); chk("lockresp.host_ready", host_ready, 1); chk("lockresp.cpu_ready", cpu_ready, 0); nxt();
      host_re = 1'b0; host_lock = 1'b0;
      @(negedge clk); chk("lockresp.unlock_addr", mem_addr, 'h60); nxt();
      @(negedge clk); chk("lockresp.unlock_ready", cpu_ready, 1); nxt();
      clear_inputs();

      // reset in a response cycle: ready suppressed, last_grant back to HOST so CPU wins the next tie
      cpu_re = 1'b1; cpu_addr = 'h80;
      @(negedge clk); chk("rstresp.grant", mem_re, 1); nxt();
      reset = 1'b1;
      @(negedge clk); chk("rstresp.ready_off", cpu_ready, 0); nxt();
      reset = 1'b0; host_re = 1'b1; host_addr = 'h90;
      @(negedge clk); chk("rstresp.tie_cpu", mem_addr, 'h80); nxt();
      @(negedge clk); chk("rstresp.cpu_ready", cpu_ready, 1); nxt();
      cpu_re = 1'b0;
      @(negedge clk); chk("rstresp.host_addr", mem_addr, 'h90); nxt();
      @(negedge clk); chk("rstresp.host_ready", host_ready, 1); nxt();
      clear_inputs();

      // both busy under lock, then unlock: CPU must complete within a few cycles
      host_lock = 1'b1; cpu_re = 1'b1; cpu_addr = 'hB0; host_re = 1'b1; host_addr = 'hA0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); chk($sformatf("fair.locked%0d", k), cpu_ready, 0); nxt();
      end
      host_lock = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin
         @(negedge clk);
         if (cpu_ready) got = 1'b1;
         nxt();
      end
      chk("fair.cpu_done", got, 1);
      cpu_re = 1'b0;
      for (int k = 0; k < 3; k++) nxt();
      clear_inputs();
      nxt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
